// File: rtl/smvm_pkg.sv
// Shared types and defaults for the sparse matrix-vector row feeder.
package smvm_pkg;

  localparam int DEF_MAX_COLS = 16;
  localparam int DEF_DONE_GAP = 2;
  localparam int DATA_W       = 32;
  localparam int ENTRY_W      = 2 * DATA_W;
  localparam int ROWS_W       = 16;
  localparam int GAP_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DROP,
    ISSUE_HDR,
    ISSUE_COL,
    WAIT_DONE
  } feeder_state_e;

  // States in which the feeder takes words from upstream.
  function automatic logic is_input_state(feeder_state_e s);
    return (s == IDLE) || (s == LOAD) || (s == DROP);
  endfunction

endpackage

// File: rtl/row_buffer.sv
// Row storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; every read slot is written before use.
module row_buffer
  import smvm_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_COLS,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Write one entry per accepted column word.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/row_feeder.sv
// Buffers one sparse row (header + n column entries) and replays it to the
// accumulator as a header pulse followed by n back-to-back column cycles.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high; in_ready is registered and never depends on in_valid.
// All outputs are registered; their next values are derived from the next
// state so each output lines up with the state it belongs to.
module row_feeder
  import smvm_pkg::*;
#(
  parameter int MAX_COLS = DEF_MAX_COLS,
  parameter int DONE_GAP = DEF_DONE_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              compute_start,
  input  logic              acc_done,
  output logic              busy,
  output logic              err_overflow,
  output logic [ROWS_W-1:0] rows_issued
);

  localparam int                IDX_W    = $clog2(MAX_COLS);
  localparam logic [DATA_W-1:0] MAX_N    = DATA_W'(MAX_COLS);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(DONE_GAP);

  feeder_state_e state_q, state_d;

  logic [DATA_W-1:0] row_q, row_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              err_q, err_d;
  logic [ROWS_W-1:0] rows_q, rows_d;

  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              cs_q, cs_d;
  logic [DATA_W-1:0] da_q, da_d;
  logic [DATA_W-1:0] db_q, db_d;

  logic               accept;
  logic               last_cnt;
  logic               buf_we;
  logic [IDX_W-1:0]   buf_rd_idx;
  logic [ENTRY_W-1:0] buf_rd_data;

  assign accept   = in_valid & in_ready_q;
  // cnt_q counts words of the current phase; n_q >= 1 whenever this is used.
  assign last_cnt = (cnt_q == n_q - DATA_W'(1));

  row_buffer #(.DEPTH(MAX_COLS)) u_row_buffer (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_idx  (cnt_q[IDX_W-1:0]),
    .wr_data ({in_a, in_b}),
    .rd_idx  (buf_rd_idx),
    .rd_data (buf_rd_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus row bookkeeping (latched header, word counter, gap timer).
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    err_d   = err_q;
    buf_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          row_d = in_a;
          n_d   = in_b;
          cnt_d = '0;
          if (in_b == '0) begin
            state_d = ISSUE_HDR;
          end else if (in_b <= MAX_N) begin
            state_d = LOAD;
          end else begin
            state_d = DROP;
            err_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          buf_we = 1'b1;
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = ISSUE_HDR;
          end else begin
            cnt_d = cnt_q + DATA_W'(1);
          end
        end
      end
      DROP: begin
        if (accept) begin
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + DATA_W'(1);
          end
        end
      end
      ISSUE_HDR: begin
        cnt_d = '0;
        if (n_q != '0) begin
          state_d = ISSUE_COL;
        end else begin
          state_d = WAIT_DONE;
          gap_d   = GAP_LOAD;
        end
      end
      ISSUE_COL: begin
        if (last_cnt) begin
          cnt_d   = '0;
          gap_d   = GAP_LOAD;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + DATA_W'(1);
        end
      end
      WAIT_DONE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (acc_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values, keyed on the state being entered.
  always_comb begin
    in_ready_d = is_input_state(state_d);
    busy_d     = (state_d != IDLE);
    cs_d       = (state_d == ISSUE_HDR);
    rows_d     = rows_q;
    da_d       = '0;
    db_d       = '0;
    buf_rd_idx = cnt_d[IDX_W-1:0];
    if (state_d == ISSUE_HDR) begin
      rows_d = rows_q + ROWS_W'(1);
      da_d   = row_d;
      db_d   = n_d;
    end else if (state_d == ISSUE_COL) begin
      da_d = buf_rd_data[ENTRY_W-1:DATA_W];
      db_d = buf_rd_data[DATA_W-1:0];
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q      <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      rows_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b0;
      da_q       <= '0;
      db_q       <= '0;
    end else begin
      row_q      <= row_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      rows_q     <= rows_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      da_q       <= da_d;
      db_q       <= db_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign compute_start = cs_q;
  assign data_a        = da_q;
  assign data_b        = db_q;
  assign err_overflow  = err_q;
  assign rows_issued   = rows_q;

endmodule

// File: tb/tb_row_feeder.sv
// Bench for row_feeder: directed rows plus randomized rows checked against a
// word-level model (expected output queue, row count, sticky error flag).
module tb_row_feeder;

  localparam int MAX_COLS = 16;
  localparam int DONE_GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] data_a, data_b;
  logic        compute_start;
  logic        acc_done;
  logic        busy;
  logic        err_overflow;
  logic [15:0] rows_issued;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [63:0] exp_q[$];
  int          exp_rows = 0;
  logic        exp_err  = 1'b0;
  logic [63:0] ent [64];
  int          pulse_cnt = 0;

  row_feeder #(.MAX_COLS(MAX_COLS), .DONE_GAP(DONE_GAP)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .data_a        (data_a),
    .data_b        (data_b),
    .compute_start (compute_start),
    .acc_done      (acc_done),
    .busy          (busy),
    .err_overflow  (err_overflow),
    .rows_issued   (rows_issued)
  );

  // Clock.
  always #5 clk = ~clk;

  // Count header pulses seen since the last reset.
  always @(negedge clk) begin
    if (rst) pulse_cnt = 0;
    else if (compute_start) pulse_cnt = pulse_cnt + 1;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // Drive one word and hold it until it transfers (bounded). Starts and ends
  // 1ns after a rising edge.
  task automatic send_word(input logic [31:0] a, input logic [31:0] b, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
    if (gaps) #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_word_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  // After a row's last column (or header for n=0) the accumulator is released.
  // hold=0: acc_done already high, expect exactly DONE_GAP+1 WAIT_DONE cycles.
  // hold>0: acc_done low for hold cycles, then high; IDLE on the next cycle.
  task automatic finish_row(input int hold);
    int cyc;
    logic bad;
    if (hold == 0) begin
      cyc = 0;
      @(negedge clk);
      while (busy && cyc < 40) begin
        cyc++;
        @(negedge clk);
      end
      n_cmp++;
      if (cyc !== DONE_GAP) begin
        n_err++;
        $display("FAIL done_gap: extra wait cycles=%0d required %0d", cyc, DONE_GAP);
      end
      @(posedge clk);
      #1;
    end else begin
      bad = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL wait_hold: in_ready=%b busy=%b required 0/1 while acc_done low", in_ready, busy);
      end
      @(posedge clk);
      #1;
      acc_done = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL wait_release_early: busy=%b required 1 before acc_done sampled", busy);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL wait_release: busy=%b in_ready=%b required 0/1", busy, in_ready);
      end
    end
  endtask

  // Send a full row using ent[0..n-1] and check the replay against the model.
  task automatic do_row(input logic [31:0] row, input int n, input bit gaps, input int hold);
    logic [63:0] exp;
    acc_done = (hold == 0);
    send_word(row, 32'(n), 1'b0);
    if (n > MAX_COLS) begin
      for (int i = 0; i < n; i++) send_word(ent[i][63:32], ent[i][31:0], gaps);
      exp_err = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || compute_start !== 1'b0 || data_a !== 32'd0 || data_b !== 32'd0 ||
          err_overflow !== exp_err) begin
        n_err++;
        $display("FAIL drop_row: busy=%b cs=%b a=%h b=%h err=%b required 0/0/0/0/%b",
                 busy, compute_start, data_a, data_b, err_overflow, exp_err);
      end
      @(posedge clk);
      #1;
    end else begin
      exp_q.push_back({row, 32'(n)});
      for (int i = 0; i < n; i++) exp_q.push_back(ent[i]);
      for (int i = 0; i < n; i++) send_word(ent[i][63:32], ent[i][31:0], gaps);
      exp_rows++;
      // Header pulse exactly one cycle after the last accepted word.
      @(negedge clk);
      exp = exp_q.pop_front();
      n_cmp++;
      if (compute_start !== 1'b1 || {data_a, data_b} !== exp) begin
        n_err++;
        $display("FAIL header: cs=%b a=%h b=%h required 1 a=%h b=%h",
                 compute_start, data_a, data_b, exp[63:32], exp[31:0]);
      end
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if (compute_start !== 1'b0 || in_ready !== 1'b0 || {data_a, data_b} !== exp) begin
          n_err++;
          $display("FAIL column[%0d]: cs=%b rdy=%b a=%h b=%h required 0 0 a=%h b=%h",
                   i, compute_start, in_ready, data_a, data_b, exp[63:32], exp[31:0]);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (data_a !== 32'd0 || data_b !== 32'd0 || in_ready !== 1'b0 || busy !== 1'b1 ||
          compute_start !== 1'b0) begin
        n_err++;
        $display("FAIL wait_entry: a=%h b=%h rdy=%b busy=%b cs=%b required 0 0 0 1 0",
                 data_a, data_b, in_ready, busy, compute_start);
      end
      @(posedge clk);
      #1;
      finish_row(hold);
    end
    n_cmp++;
    if (rows_issued !== 16'(exp_rows) || pulse_cnt !== exp_rows || err_overflow !== exp_err) begin
      n_err++;
      $display("FAIL row_counts: rows=%0d pulses=%0d err=%b required %0d %0d %b",
               rows_issued, pulse_cnt, err_overflow, exp_rows, exp_rows, exp_err);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || compute_start !== 1'b0 || data_a !== 32'd0 ||
        data_b !== 32'd0 || err_overflow !== 1'b0 || rows_issued !== 16'd0) begin
      n_err++;
      $display("FAIL %s: rdy=%b busy=%b cs=%b a=%h b=%h err=%b rows=%0d required all 0",
               name, in_ready, busy, compute_start, data_a, data_b, err_overflow, rows_issued);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    acc_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ent[0] = {32'd2, 32'd10};
    ent[1] = {32'd7, 32'd20};
    ent[2] = {32'd9, 32'd30};
    do_row(32'd5, 3, 1'b0, 0);
  endtask

  task automatic test_zero_cols();
    do_row(32'd8, 0, 1'b0, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) ent[i] = {$urandom(), $urandom()};
    do_row(32'd40, 17, 1'b0, 0);
    for (int i = 0; i < 2; i++) ent[i] = {$urandom(), $urandom()};
    do_row(32'd41, 2, 1'b0, 0);
  endtask

  task automatic test_full_row();
    for (int i = 0; i < MAX_COLS; i++) ent[i] = {$urandom(), $urandom()};
    do_row(32'hFFFF_FFFF, MAX_COLS, 1'b0, 0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) ent[i] = {$urandom(), $urandom()};
    do_row(32'd77, 4, 1'b1, 0);
  endtask

  task automatic test_wait_done();
    ent[0] = {32'd1, 32'd99};
    do_row(32'd3, 1, 1'b0, 20);
  endtask

  task automatic test_reset_mid_row();
    acc_done = 1'b1;
    send_word(32'd11, 32'd3, 1'b0);
    send_word(32'd1, 32'd100, 1'b0);
    send_word(32'd2, 32'd200, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_row");
    exp_q.delete();
    exp_rows = 0;
    exp_err  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ent[0] = {32'd4, 32'd40};
    ent[1] = {32'd5, 32'd50};
    ent[2] = {32'd6, 32'd60};
    do_row(32'd12, 3, 1'b0, 0);
  endtask

  task automatic test_random();
    int n;
    int hold;
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 20);
      hold = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(DONE_GAP, 6);
      for (int i = 0; i < n; i++) ent[i] = {$urandom(), $urandom()};
      do_row($urandom(), n, 1'($urandom_range(0, 1)), hold);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cols();
    test_overflow();
    test_full_row();
    test_stall();
    test_wait_done();
    test_reset_mid_row();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
